// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide, synchronous-read RAM port between the
// instruction-fetch port (IF) and the load/store port (LS). A granted request
// is split into 1, 2 or 4 little-endian byte beats. Read bytes are reassembled
// into a word, and LS loads are sign- or zero-extended.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_if_*            fetch request/address/cancel; o_if_rdata, o_if_done
//   i_ls_*            load/store request fields; o_ls_rdata, o_ls_done
//   o_mem_a/_wr/_dout RAM address, write strobe and write byte
//   i_mem_din         RAM read byte, valid the cycle after its address
//   o_busy            arbiter is not idle
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_if_cancel,
    output logic [31:0]       o_if_rdata,
    output logic              o_if_done,
    input  logic              i_ls_req,
    input  logic              i_ls_we,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [1:0]        i_ls_size,
    input  logic              i_ls_unsigned,
    input  logic [31:0]       i_ls_wdata,
    output logic [31:0]       o_ls_rdata,
    output logic              o_ls_done,
    output logic [ADDR_W-1:0] o_mem_a,
    output logic              o_mem_wr,
    output logic [7:0]        o_mem_dout,
    input  logic [7:0]        i_mem_din,
    output logic              o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_k, r_n;      // beat counter and beat count
    logic [ADDR_W-1:0]   r_addr;
    logic                r_is_ls, r_uns;
    logic [1:0]          r_size;
    logic [31:0]         r_wdata, r_buf, r_if_rdata, r_ls_rdata;
    logic [ADDR_W-1:0]   r_mem_a;
    logic                r_mem_wr;
    logic [7:0]          r_mem_dout;

    logic                w_grant_ls, w_grant_if, w_cancel;
    logic [2:0]          w_k1;
    logic [31:0]         w_word, w_ext;
    logic [7:0]          w_wbyte;

    function automatic logic [2:0] size_to_n(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    always_comb begin
        w_grant_ls = (r_state == S_IDLE) && i_ls_req;
        w_grant_if = (r_state == S_IDLE) && !i_ls_req && i_if_req && !i_if_cancel;
        w_cancel   = (r_state == S_RD) && !r_is_ls && i_if_cancel;
        w_k1       = r_k + 3'd1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_ls)      w_state_nxt = i_ls_we ? S_WR : S_RD;
                else if (w_grant_if) w_state_nxt = S_RD;
            end
            S_RD: begin
                if (w_cancel)        w_state_nxt = S_IDLE;
                else if (r_k == r_n) w_state_nxt = S_DONE;
            end
            S_WR: begin
                if (r_k == r_n - 3'd1) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // The byte arriving on i_mem_din belongs to beat k-1 (one-cycle RAM latency).
    always_comb begin
        w_word = r_buf;
        case (r_k)
            3'd1:    w_word[7:0]   = i_mem_din;
            3'd2:    w_word[15:8]  = i_mem_din;
            3'd3:    w_word[23:16] = i_mem_din;
            3'd4:    w_word[31:24] = i_mem_din;
            default: ;
        endcase
        case (r_size)
            2'b00:   w_ext = {{24{~r_uns & w_word[7]}}, w_word[7:0]};
            2'b01:   w_ext = {{16{~r_uns & w_word[15]}}, w_word[15:0]};
            default: w_ext = w_word;
        endcase
        case (w_k1[1:0])
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k        <= '0;
            r_n        <= '0;
            r_addr     <= '0;
            r_is_ls    <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= '0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
            r_mem_a    <= '0;
            r_mem_wr   <= 1'b0;
            r_mem_dout <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Beat 0 is presented straight from the request so the
                    // first bus cycle follows the grant edge immediately.
                    if (w_grant_ls) begin
                        r_is_ls    <= 1'b1;
                        r_addr     <= i_ls_addr;
                        r_size     <= i_ls_size;
                        r_uns      <= i_ls_unsigned;
                        r_wdata    <= i_ls_wdata;
                        r_n        <= size_to_n(i_ls_size);
                        r_k        <= '0;
                        r_buf      <= '0;
                        r_mem_a    <= i_ls_addr;
                        r_mem_wr   <= i_ls_we;
                        r_mem_dout <= i_ls_wdata[7:0];
                    end else if (w_grant_if) begin
                        r_is_ls  <= 1'b0;
                        r_addr   <= i_if_addr;
                        r_size   <= 2'b10;
                        r_n      <= 3'd4;
                        r_k      <= '0;
                        r_buf    <= '0;
                        r_mem_a  <= i_if_addr;
                        r_mem_wr <= 1'b0;
                    end
                end
                S_RD: begin
                    if (!w_cancel) begin
                        r_buf <= w_word;
                        r_k   <= w_k1;
                        if (w_k1 < r_n) r_mem_a <= r_addr + ADDR_W'(w_k1);
                        if (r_k == r_n) begin
                            if (r_is_ls) r_ls_rdata <= w_ext;
                            else         r_if_rdata <= w_word;
                        end
                    end
                end
                S_WR: begin
                    r_k <= w_k1;
                    if (r_k == r_n - 3'd1) begin
                        r_mem_wr <= 1'b0;
                    end else begin
                        r_mem_a    <= r_addr + ADDR_W'(w_k1);
                        r_mem_dout <= w_wbyte;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_if_rdata = r_if_rdata;
    assign o_ls_rdata = r_ls_rdata;
    assign o_if_done  = (r_state == S_DONE) && !r_is_ls;
    assign o_ls_done  = (r_state == S_DONE) && r_is_ls;
    assign o_mem_a    = r_mem_a;
    assign o_mem_wr   = r_mem_wr;
    assign o_mem_dout = r_mem_dout;
    assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a byte RAM responder, a byte-array
// reference memory and scenario tasks plus a randomized mix of transactions.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_cancel = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        ls_req = 1'b0, ls_we = 1'b0, ls_unsigned = 1'b0;
    logic [31:0] ls_addr = '0, ls_wdata = '0;
    logic [1:0]  ls_size = '0;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_cancel(if_cancel),
        .o_if_rdata(if_rdata), .o_if_done(if_done),
        .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr),
        .i_ls_size(ls_size), .i_ls_unsigned(ls_unsigned), .i_ls_wdata(ls_wdata),
        .o_ls_rdata(ls_rdata), .o_ls_done(ls_done),
        .o_mem_a(mem_a), .o_mem_wr(mem_wr), .o_mem_dout(mem_dout),
        .i_mem_din(mem_din), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // RAM responder: 1 KiB image indexed by the low address bits.
    logic [7:0]  ram [0:1023];
    bit          ram_ready = 1'b0;
    logic        pk_en = 1'b0;
    logic [9:0]  pk_a = '0;
    logic [7:0]  pk_d = '0;
    logic [39:0] wlog[$];
    logic [31:0] alog[$];

    // Reference memory, updated only from the expected effect of each request.
    logic [7:0]  mdl [0:1023];
    logic [31:0] exp_if = '0, exp_ls = '0;

    function automatic logic [7:0] hash(input int i);
        return 8'(i * 37 + 91);
    endfunction

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) ram[i] <= hash(i);
            ram_ready <= 1'b1;
        end else begin
            if (pk_en) ram[pk_a] <= pk_d;
            if (mem_wr) begin
                ram[mem_a[9:0]] <= mem_dout;
                wlog.push_back({mem_a, mem_dout});
            end
        end
        mem_din <= ram[mem_a[9:0]];
        if (busy) alog.push_back(mem_a);
    end

    function automatic int size_n(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Little-endian read of n bytes, then extension by arithmetic.
    function automatic logic [31:0] exp_read(input logic [31:0] a, input int n, input logic uns);
        logic [31:0] v;
        logic [31:0] ad;
        v = '0;
        for (int j = 0; j < n; j++) begin
            ad = a + 32'(j);
            v = v | (32'(mdl[ad[9:0]]) << (8 * j));
        end
        if (n < 4 && !uns && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        pk_en = 1'b1; pk_a = a[9:0]; pk_d = d;
        mdl[a[9:0]] = d;
        @(posedge clk); #1;
        pk_en = 1'b0;
    endtask

    task automatic wait_idle;
        for (int c = 0; c < 20; c++) begin
            if (!busy) break;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b required 0", busy); end
    endtask

    // Drives one LS request; lat = edges from grant edge to done (-1 on timeout).
    task automatic ls_op(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd);
        wait_idle();
        @(negedge clk);
        ls_req = 1'b1; ls_we = we; ls_addr = a; ls_size = sz; ls_unsigned = uns; ls_wdata = wd;
        wlog.delete(); alog.delete();
        @(posedge clk); #1;
        // Fields are latched at grant; wiggle them to show they are ignored.
        ls_addr = $urandom; ls_wdata = $urandom; ls_size = 2'($urandom);
        ls_unsigned = 1'($urandom); ls_we = 1'($urandom);
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (ls_done) begin lat = c; break; end
        end
        rd = ls_rdata;
        ls_req = 1'b0;
    endtask

    task automatic if_op(input logic [31:0] a, output int lat, output logic [31:0] rd);
        wait_idle();
        @(negedge clk);
        if_req = 1'b1; if_addr = a;
        wlog.delete(); alog.delete();
        @(posedge clk); #1;
        if_addr = $urandom;
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (if_done) begin lat = c; break; end
        end
        rd = if_rdata;
        if_req = 1'b0;
    endtask

    task automatic test_reset;
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mem_wr !== 1'b0)   begin errors++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        checks++; if (mem_a !== 32'h0)   begin errors++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        checks++; if ({if_done, ls_done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {if_done, ls_done}); end
        checks++; if ({if_rdata, ls_rdata, mem_dout} !== 72'h0) begin errors++; $display("FAIL reset_data: got %h %h %h want 0", if_rdata, ls_rdata, mem_dout); end
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_if_fetch;
        int lat; logic [31:0] rd;
        poke(32'h10, 8'h11); poke(32'h11, 8'h22); poke(32'h12, 8'h33); poke(32'h13, 8'h44);
        if_op(32'h10, lat, rd);
        checks++; if (lat !== 5) begin errors++; $display("FAIL if_fetch_latency: got %0d want 5", lat); end
        checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL if_fetch_data: got %h want 44332211", rd); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (alog.size() < 4 || alog[j] !== 32'h10 + 32'(j)) begin
                errors++; $display("FAIL if_fetch_addr%0d: got %h want %h", j, (alog.size() > j) ? alog[j] : 32'hx, 32'h10 + 32'(j));
            end
        end
        exp_if = 32'h44332211;
    endtask

    task automatic test_priority;
        int lat_ls, lat_if, if_early;
        wait_idle();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20; ls_size = 2'b10; ls_unsigned = 1'b0;
        @(posedge clk); #1;
        lat_ls = -1; if_early = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (if_done) if_early++;
            if (ls_done) begin lat_ls = c; break; end
        end
        checks++; if (lat_ls !== 5) begin errors++; $display("FAIL prio_ls_latency: got %0d want 5", lat_ls); end
        checks++; if (if_early !== 0) begin errors++; $display("FAIL prio_if_first: got %0d if_done pulses want 0", if_early); end
        checks++; if (ls_rdata !== exp_read(32'h20, 4, 1'b1)) begin errors++; $display("FAIL prio_ls_data: got %h want %h", ls_rdata, exp_read(32'h20, 4, 1'b1)); end
        exp_ls = exp_read(32'h20, 4, 1'b1);
        ls_req = 1'b0;
        lat_if = -1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (if_done) begin lat_if = c; break; end
        end
        checks++; if (lat_if !== 7) begin errors++; $display("FAIL prio_if_latency: got %0d want 7", lat_if); end
        checks++; if (if_rdata !== 32'h44332211) begin errors++; $display("FAIL prio_if_data: got %h want 44332211", if_rdata); end
        if_req = 1'b0;
    endtask

    task automatic test_byte_load;
        int lat; logic [31:0] rd;
        poke(32'h31, 8'h80);
        ls_op(1'b0, 32'h31, 2'b00, 1'b0, 32'h0, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sbyte_latency: got %0d want 2", lat); end
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL sbyte_data: got %h want ffffff80", rd); end
        ls_op(1'b0, 32'h31, 2'b00, 1'b1, 32'h0, lat, rd);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL ubyte_data: got %h want 00000080", rd); end
        exp_ls = 32'h00000080;
    endtask

    task automatic test_half_store;
        int lat; logic [31:0] rd;
        ls_op(1'b1, 32'h100, 2'b01, 1'b0, 32'h1234BEEF, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL hstore_latency: got %0d want 2", lat); end
        checks++; if (wlog.size() !== 2) begin errors++; $display("FAIL hstore_beats: got %0d want 2", wlog.size()); end
        checks++; if (wlog.size() < 1 || wlog[0] !== 40'h00000100EF) begin errors++; $display("FAIL hstore_beat0: got %h want 00000100ef", (wlog.size() > 0) ? wlog[0] : 40'hx); end
        checks++; if (wlog.size() < 2 || wlog[1] !== 40'h00000101BE) begin errors++; $display("FAIL hstore_beat1: got %h want 00000101be", (wlog.size() > 1) ? wlog[1] : 40'hx); end
        checks++; if (rd !== exp_ls) begin errors++; $display("FAIL hstore_rdata_kept: got %h want %h", rd, exp_ls); end
        mdl[10'h100] = 8'hEF; mdl[10'h101] = 8'hBE;
    endtask

    task automatic test_cancel;
        int lat;
        wait_idle();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h50;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        if_cancel = 1'b1; if_addr = 32'h40;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_idle: busy=%b want 0", busy); end
        checks++; if (if_rdata !== exp_if) begin errors++; $display("FAIL cancel_rdata_kept: got %h want %h", if_rdata, exp_if); end
        if_cancel = 1'b0;
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (if_done) begin lat = c; break; end
        end
        checks++; if (lat !== 6) begin errors++; $display("FAIL cancel_refetch_latency: got %0d want 6", lat); end
        checks++; if (if_rdata !== exp_read(32'h40, 4, 1'b1)) begin errors++; $display("FAIL cancel_refetch_data: got %h want %h", if_rdata, exp_read(32'h40, 4, 1'b1)); end
        exp_if = exp_read(32'h40, 4, 1'b1);
        if_req = 1'b0;
    endtask

    task automatic test_reset_mid_store;
        int lat; logic [31:0] rd, w;
        wait_idle();
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_size = 2'b10; ls_wdata = 32'hA1B2C3D4;
        wlog.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; ls_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rstmid_mem_wr: got %b want 0", mem_wr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (ls_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h want 0", ls_rdata); end
        @(posedge clk); #1;
        checks++; if (ls_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %b want 0", ls_done); end
        rst = 1'b0;
        checks++; if (wlog.size() !== 2) begin errors++; $display("FAIL rstmid_beats: got %0d want 2", wlog.size()); end
        mdl[10'h200] = 8'hD4; mdl[10'h201] = 8'hC3;
        exp_if = '0; exp_ls = '0;
        ls_op(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, lat, rd);
        checks++; if (rd !== exp_read(32'h200, 4, 1'b1)) begin errors++; $display("FAIL rstmid_readback: got %h want %h", rd, exp_read(32'h200, 4, 1'b1)); end
        exp_ls = exp_read(32'h200, 4, 1'b1);
        // Wrap-around: word store at the top of the address space.
        ls_op(1'b1, 32'hFFFFFFFE, 2'b10, 1'b0, 32'h55667788, lat, rd);
        for (int j = 0; j < 4; j++) begin
            w = 32'hFFFFFFFE + 32'(j);
            checks++;
            if (wlog.size() != 4 || wlog[j] !== {w, 8'(32'h55667788 >> (8 * j))}) begin
                errors++; $display("FAIL wrap_beat%0d: got %h want %h", j, (wlog.size() > j) ? wlog[j] : 40'hx, {w, 8'(32'h55667788 >> (8 * j))});
            end
            mdl[w[9:0]] = 8'(32'h55667788 >> (8 * j));
        end
        if_op(32'hFFFFFFFE, lat, rd);
        checks++; if (rd !== 32'h55667788) begin errors++; $display("FAIL wrap_fetch: got %h want 55667788", rd); end
        exp_if = rd;
    endtask

    task automatic test_random;
        int kind, n, lat;
        logic [31:0] a, wd, rd, expv, w;
        logic [1:0]  sz;
        logic        uns;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(2, 0);
            a  = ($urandom_range(7, 0) == 0) ? 32'hFFFFFFFC + $urandom_range(3, 0) : 32'h300 + $urandom_range(127, 0);
            sz = 2'($urandom); uns = 1'($urandom); wd = $urandom;
            n  = size_n(sz);
            if (kind == 0) begin
                expv = exp_read(a, 4, 1'b1);
                if_op(a, lat, rd);
                checks++; if (lat !== 5 || rd !== expv) begin errors++; $display("FAIL rnd_fetch[%0d] @%h: got lat %0d data %h want 5 %h", it, a, lat, rd, expv); end
                exp_if = expv;
            end else if (kind == 1) begin
                expv = exp_read(a, n, uns);
                ls_op(1'b0, a, sz, uns, 32'h0, lat, rd);
                checks++; if (lat !== n + 1 || rd !== expv) begin errors++; $display("FAIL rnd_load[%0d] @%h sz%0d u%0d: got lat %0d data %h want %0d %h", it, a, sz, uns, lat, rd, n + 1, expv); end
                checks++; if (if_rdata !== exp_if) begin errors++; $display("FAIL rnd_load_if_kept[%0d]: got %h want %h", it, if_rdata, exp_if); end
                exp_ls = expv;
            end else begin
                ls_op(1'b1, a, sz, uns, wd, lat, rd);
                checks++; if (lat !== n || rd !== exp_ls) begin errors++; $display("FAIL rnd_store[%0d] @%h: got lat %0d rdata %h want %0d %h", it, a, lat, rd, n, exp_ls); end
                checks++; if (wlog.size() !== n) begin errors++; $display("FAIL rnd_store_beats[%0d]: got %0d want %0d", it, wlog.size(), n); end
                for (int j = 0; j < n; j++) begin
                    w = a + 32'(j);
                    if (wlog.size() > j && wlog[j] !== {w, 8'(wd >> (8 * j))}) begin
                        errors++; $display("FAIL rnd_store_beat[%0d.%0d]: got %h want %h", it, j, wlog[j], {w, 8'(wd >> (8 * j))});
                    end
                    mdl[w[9:0]] = 8'(wd >> (8 * j));
                end
            end
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mdl[i] = hash(i);
        test_reset();
        test_if_fetch();
        test_priority();
        test_byte_load();
        test_half_store();
        test_cancel();
        test_reset_mid_store();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
